mc_controller: RTL

Multicycle sequencing controller for the RV32I core. It drives a shared-memory, multicycle variant of the core datapath: one memory port for both fetch and data, with IR, OldPC and ALUOut registers. It decodes the latched instruction, walks a Moore FSM through fetch, decode, execute, memory and writeback, and stalls on a memory ready handshake. Illegal instructions put it into a sticky halt.

---
 rtl/rv_ctrl_pkg.sv | 73 +++++++
 rtl/mc_alu_decoder.sv | 40 ++++
 rtl/mc_controller.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_ctrl_pkg
// Brief    : State, opcode and datapath-select codes shared by the multicycle
//            RV32I sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JAL      = 4'd10,
        ST_JALR     = 4'd11,
        ST_LINK     = 4'd12,
        ST_UPPER    = 4'd13,
        ST_TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [3:0] c_alu_add  = 4'b0000;
    localparam logic [3:0] c_alu_sub  = 4'b0001;
    localparam logic [3:0] c_alu_and  = 4'b0010;
    localparam logic [3:0] c_alu_or   = 4'b0011;
    localparam logic [3:0] c_alu_xor  = 4'b0100;
    localparam logic [3:0] c_alu_slt  = 4'b0101;
    localparam logic [3:0] c_alu_sltu = 4'b0110;
    localparam logic [3:0] c_alu_sll  = 4'b0111;
    localparam logic [3:0] c_alu_srl  = 4'b1000;
    localparam logic [3:0] c_alu_sra  = 4'b1001;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_b = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b011;
    localparam logic [2:0] c_imm_u = 3'b100;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;
    localparam logic [1:0] c_srca_zero  = 2'b11;

    localparam logic [1:0] c_srcb_rs2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_readdata  = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mc_alu_decoder
// Brief    : Maps ALUOp plus funct fields to the ALU operation code.
// Revision : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] ALUControl
);

    always_comb begin
        ALUControl = c_alu_add;
        case (ALUOp)
            c_aluop_sub: ALUControl = c_alu_sub;
            c_aluop_funct: begin
                case (funct3)
                    // bit 30 of an I-type is immediate data, so only R-type can subtract
                    3'b000: ALUControl = (op5 && funct7b5) ? c_alu_sub : c_alu_add;
                    3'b001: ALUControl = c_alu_sll;
                    3'b010: ALUControl = c_alu_slt;
                    3'b011: ALUControl = c_alu_sltu;
                    3'b100: ALUControl = c_alu_xor;
                    3'b101: ALUControl = funct7b5 ? c_alu_sra : c_alu_srl;
                    3'b110: ALUControl = c_alu_or;
                    3'b111: ALUControl = c_alu_and;
                    default: ALUControl = c_alu_add;
                endcase
            end
            default: ALUControl = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Brief    : Moore sequencing FSM for the shared-memory multicycle RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller
    import rv_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = ST_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       less_than,
    input  logic       unsigned_less_than,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       jalr,
    output logic       halt
);

    state_t     r_state;
    logic [1:0] w_alu_op;
    logic       w_cond;
    logic       w_taken;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_halt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= RESET_STATE;
        end else begin
            case (r_state)
                ST_FETCH:    if (mem_ready) r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (op)
                        c_op_load, c_op_store: r_state <= ST_MEMADR;
                        c_op_r:                r_state <= ST_EXECR;
                        c_op_imm:              r_state <= ST_EXECI;
                        c_op_branch:           r_state <= (funct3[2:1] == 2'b01) ? ST_TRAP : ST_BRANCH;
                        c_op_jal:              r_state <= ST_JAL;
                        c_op_jalr:             r_state <= ST_JALR;
                        c_op_lui, c_op_auipc:  r_state <= ST_UPPER;
                        default:               r_state <= ST_TRAP;
                    endcase
                end
                ST_MEMADR:   r_state <= op[5] ? ST_MEMWRITE : ST_MEMREAD;
                ST_MEMREAD:  if (mem_ready) r_state <= ST_MEMWB;
                ST_MEMWB:    r_state <= ST_FETCH;
                ST_MEMWRITE: if (mem_ready) r_state <= ST_FETCH;
                ST_EXECR:    r_state <= ST_ALUWB;
                ST_EXECI:    r_state <= ST_ALUWB;
                ST_ALUWB:    r_state <= ST_FETCH;
                ST_BRANCH:   r_state <= ST_FETCH;
                ST_JAL:      r_state <= ST_ALUWB;
                ST_JALR:     r_state <= ST_LINK;
                ST_LINK:     r_state <= ST_ALUWB;
                ST_UPPER:    r_state <= ST_ALUWB;
                ST_TRAP:     r_state <= ST_TRAP;
                default:     r_state <= ST_FETCH;
            endcase
        end
    end

    // funct3[0] inverts the base comparison (bne/bge/bgeu)
    always_comb begin
        case (funct3[2:1])
            2'b00:   w_cond = Zero;
            2'b10:   w_cond = less_than;
            2'b11:   w_cond = unsigned_less_than;
            default: w_cond = 1'b0;
        endcase
        w_taken = w_cond ^ funct3[0];
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_halt      = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = c_srca_pc;
        ALUSrcB     = c_srcb_rs2;
        ResultSrc   = c_res_aluout;
        w_alu_op    = c_aluop_add;
        jalr        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_pc_write = mem_ready;
                w_ir_write = mem_ready;
                ALUSrcB    = c_srcb_four;
                ResultSrc  = c_res_aluresult;
            end
            ST_DECODE: begin
                ALUSrcA = c_srca_oldpc;
                ALUSrcB = c_srcb_imm;
            end
            ST_MEMADR: begin
                ALUSrcA = c_srca_rs1;
                ALUSrcB = c_srcb_imm;
            end
            ST_MEMREAD: AdrSrc = 1'b1;
            ST_MEMWB: begin
                ResultSrc   = c_res_readdata;
                w_reg_write = 1'b1;
            end
            ST_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            ST_EXECR: begin
                ALUSrcA  = c_srca_rs1;
                w_alu_op = c_aluop_funct;
            end
            ST_EXECI: begin
                ALUSrcA  = c_srca_rs1;
                ALUSrcB  = c_srcb_imm;
                w_alu_op = c_aluop_funct;
            end
            ST_ALUWB: w_reg_write = 1'b1;
            ST_BRANCH: begin
                ALUSrcA    = c_srca_rs1;
                w_alu_op   = c_aluop_sub;
                w_pc_write = w_taken;
            end
            ST_JAL: begin
                ALUSrcA    = c_srca_oldpc;
                ALUSrcB    = c_srcb_four;
                w_pc_write = 1'b1;
            end
            ST_JALR: begin
                ALUSrcA    = c_srca_rs1;
                ALUSrcB    = c_srcb_imm;
                ResultSrc  = c_res_aluresult;
                jalr       = 1'b1;
                w_pc_write = 1'b1;
            end
            ST_LINK: begin
                ALUSrcA = c_srca_oldpc;
                ALUSrcB = c_srcb_four;
            end
            ST_UPPER: begin
                ALUSrcA = op[5] ? c_srca_zero : c_srca_oldpc;
                ALUSrcB = c_srcb_imm;
            end
            ST_TRAP: w_halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            c_op_store:           ImmSrc = c_imm_s;
            c_op_branch:          ImmSrc = c_imm_b;
            c_op_jal:             ImmSrc = c_imm_j;
            c_op_lui, c_op_auipc: ImmSrc = c_imm_u;
            default:              ImmSrc = c_imm_i;
        endcase
    end

    // Reset suppresses every write so an abandoned instruction leaves no trace
    assign PCWrite  = reset & w_pc_write;
    assign IRWrite  = reset & w_ir_write;
    assign MemWrite = reset & w_mem_write;
    assign RegWrite = reset & w_reg_write;
    assign halt     = reset & w_halt;

    mc_alu_decoder u_alu_decoder (
        .ALUOp      (w_alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .ALUControl (ALUControl)
    );

endmodule
`default_nettype wire
